// File: rtl/regfile_scoreboard.sv
// Integer register file with x0 tied to zero, write-to-read bypass,
// a per-register busy scoreboard and a handshaked register-dump engine.
module regfile_scoreboard #(
    parameter int REGISTER_WIDTH   = 64,
    parameter int REGISTERNO_WIDTH = 5,
    parameter int NUM_READ_PORTS   = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_READ_PORTS*REGISTERNO_WIDTH-1:0] in_rs_regno,
    output logic [NUM_READ_PORTS*REGISTER_WIDTH-1:0]   out_rs_value,
    output logic [NUM_READ_PORTS-1:0]                  out_rs_busy,
    input  logic                                       in_wr_enable,
    input  logic [REGISTERNO_WIDTH-1:0]                in_rd_regno,
    input  logic [REGISTER_WIDTH-1:0]                  in_rd_value,
    input  logic                                       in_issue_valid,
    input  logic [REGISTERNO_WIDTH-1:0]                in_issue_regno,
    input  logic                                       in_dump_req,
    input  logic                                       in_dump_ready,
    output logic                                       out_dump_valid,
    output logic [REGISTERNO_WIDTH-1:0]                out_dump_regno,
    output logic [REGISTER_WIDTH-1:0]                  out_dump_value,
    output logic                                       out_dump_done,
    output logic                                       out_dump_active
);

    localparam int NUM_REGS = 2 ** REGISTERNO_WIDTH;

    typedef logic [REGISTER_WIDTH-1:0]   word_t;
    typedef logic [REGISTERNO_WIDTH-1:0] regno_t;
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

    localparam regno_t LAST_IDX = regno_t'(NUM_REGS - 1);

    word_t               regs_q [NUM_REGS];
    word_t               regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    state_e              state_q;
    state_e              state_d;
    regno_t              idx_q;
    regno_t              idx_d;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (in_wr_enable && in_rd_regno != '0) begin
            regs_d[in_rd_regno] = in_rd_value;
            busy_d[in_rd_regno] = 1'b0;
        end
        // A new producer issued this cycle outranks the retiring one.
        if (in_issue_valid) begin
            busy_d[in_issue_regno] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin : rd_ports
        regno_t rs;
        logic   hit;
        logic   reissue;
        rs           = '0;
        hit          = 1'b0;
        reissue      = 1'b0;
        out_rs_value = '0;
        out_rs_busy  = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rs      = in_rs_regno[p*REGISTERNO_WIDTH +: REGISTERNO_WIDTH];
            hit     = in_wr_enable && (in_rd_regno == rs);
            reissue = in_issue_valid && (in_issue_regno == rs);
            if (rs == '0) begin
                out_rs_value[p*REGISTER_WIDTH +: REGISTER_WIDTH] = '0;
            end else if (hit) begin
                out_rs_value[p*REGISTER_WIDTH +: REGISTER_WIDTH] = in_rd_value;
            end else begin
                out_rs_value[p*REGISTER_WIDTH +: REGISTER_WIDTH] = regs_q[rs];
            end
            out_rs_busy[p] = busy_q[rs] && !(hit && !reissue);
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        out_dump_valid  = 1'b0;
        out_dump_regno  = '0;
        out_dump_value  = '0;
        out_dump_done   = 1'b0;
        out_dump_active = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_dump_req) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                out_dump_active = 1'b1;
                out_dump_valid  = 1'b1;
                out_dump_regno  = idx_q;
                out_dump_value  = regs_q[idx_q];
                if (in_dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + regno_t'(1);
                    end
                end
            end
            DONE: begin
                out_dump_active = 1'b1;
                out_dump_done   = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q  <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomised and directed bench for regfile_scoreboard, checking a
// 2-port and a 4-port build against a behavioural model.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] rs4;
    logic        wr;
    logic [4:0]  rd;
    logic [63:0] wv;
    logic        iss;
    logic [4:0]  ir;
    logic        req;
    logic        rdy;

    logic [127:0] val2;
    logic [1:0]   busy2;
    logic [255:0] val4;
    logic [3:0]   busy4;
    logic         dv2, dd2, da2, dv4, dd4, da4;
    logic [4:0]   dr2, dr4;
    logic [63:0]  dval2, dval4;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] mdl [32];
    bit          mbusy [32];
    int          dmode;
    int          didx;
    int          beats;
    int          dones;

    always #5 clk = ~clk;

    regfile_scoreboard #(.NUM_READ_PORTS(2)) dut (
        .clk(clk), .reset(reset),
        .in_rs_regno(rs4[9:0]),
        .out_rs_value(val2), .out_rs_busy(busy2),
        .in_wr_enable(wr), .in_rd_regno(rd), .in_rd_value(wv),
        .in_issue_valid(iss), .in_issue_regno(ir),
        .in_dump_req(req), .in_dump_ready(rdy),
        .out_dump_valid(dv2), .out_dump_regno(dr2),
        .out_dump_value(dval2), .out_dump_done(dd2),
        .out_dump_active(da2)
    );

    regfile_scoreboard #(.NUM_READ_PORTS(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_rs_regno(rs4),
        .out_rs_value(val4), .out_rs_busy(busy4),
        .in_wr_enable(wr), .in_rd_regno(rd), .in_rd_value(wv),
        .in_issue_valid(iss), .in_issue_regno(ir),
        .in_dump_req(req), .in_dump_ready(rdy),
        .out_dump_valid(dv4), .out_dump_regno(dr4),
        .out_dump_value(dval4), .out_dump_done(dd4),
        .out_dump_active(da4)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_val(input int r);
        if (r == 0) return 64'd0;
        if (wr && rd == 5'(r)) return wv;
        return mdl[r];
    endfunction

    function automatic logic exp_busy(input int r);
        bit hit;
        bit re;
        hit = wr && rd == 5'(r);
        re  = iss && ir == 5'(r);
        return mbusy[r] && !(hit && !re);
    endfunction

    task automatic tick();
        int r;
        #1;
        for (int p = 0; p < 4; p++) begin
            r = int'(rs4[p*5 +: 5]);
            chk($sformatf("val4_p%0d", p), val4[p*64 +: 64], exp_val(r));
            chk($sformatf("busy4_p%0d", p), 64'(busy4[p]), 64'(exp_busy(r)));
            if (p < 2) begin
                chk($sformatf("val2_p%0d", p), val2[p*64 +: 64], exp_val(r));
                chk($sformatf("busy2_p%0d", p), 64'(busy2[p]),
                    64'(exp_busy(r)));
            end
        end
        chk("dv", 64'(dv2), 64'(dmode == 1));
        chk("dr", 64'(dr2), (dmode == 1) ? 64'(didx) : 64'd0);
        chk("dval", dval2, (dmode == 1) ? mdl[didx] : 64'd0);
        chk("dd", 64'(dd2), 64'(dmode == 2));
        chk("da", 64'(da2), 64'(dmode != 0));
        chk("d4", {dval4[59:0], dr4[0], dv4, dd4, da4},
            {dval2[59:0], dr2[0], dv2, dd2, da2});
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mdl[i]   = '0;
                mbusy[i] = 1'b0;
            end
            dmode = 0;
            didx  = 0;
        end else begin
            if (dmode == 1 && rdy) beats++;
            if (dmode == 2) dones++;
            case (dmode)
                0: if (req) begin dmode = 1; didx = 0; end
                1: if (rdy) begin
                       if (didx == 31) dmode = 2;
                       else didx++;
                   end
                default: dmode = 0;
            endcase
            if (wr && rd != 0) begin
                mdl[rd]   = wv;
                mbusy[rd] = 1'b0;
            end
            if (iss && ir != 0) mbusy[ir] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle_in();
        reset = 0; wr = 0; rd = 0; wv = 0; iss = 0; ir = 0;
        req = 0; rdy = 0;
    endtask

    initial begin
        int b0;
        int d0;
        dmode = 0; didx = 0; beats = 0; dones = 0;
        for (int i = 0; i < 32; i++) begin
            mdl[i] = '0; mbusy[i] = 1'b0;
        end
        idle_in();
        rs4 = '0;
        reset = 1;
        @(negedge clk);
        tick();
        tick();
        reset = 0;
        for (int i = 0; i < 32; i++) begin
            for (int p = 0; p < 4; p++) rs4[p*5 +: 5] = 5'((i + p) % 32);
            tick();
        end
        wr = 1; rd = 5; wv = 64'hDEAD;
        tick();
        wr = 0; rs4[4:0] = 5;
        #1 chk("x5_read", val2[63:0], 64'hDEAD);
        tick();
        wr = 1; rd = 0; wv = 64'h1234; rs4[9:5] = 0;
        #1 chk("x0_wr_same", val2[127:64], 64'd0);
        tick();
        wr = 0; iss = 1; ir = 0;
        #1 chk("x0_wr_next", val2[127:64], 64'd0);
        tick();
        iss = 0;
        #1 chk("x0_busy", 64'(busy2[1]), 64'd0);
        tick();
        wr = 1; rd = 7; wv = 1;
        tick();
        wv = 99; rs4[4:0] = 7;
        #1 chk("byp_val", val2[63:0], 64'd99);
        chk("byp_busy", 64'(busy2[0]), 64'd0);
        tick();
        wr = 0;
        #1 chk("byp_next", val2[63:0], 64'd99);
        tick();
        iss = 1; ir = 3; rs4[4:0] = 3;
        tick();
        iss = 0;
        #1 chk("sb_set", 64'(busy2[0]), 64'd1);
        tick();
        wr = 1; rd = 3; wv = 33; iss = 1; ir = 3;
        tick();
        wr = 0; iss = 0;
        #1 chk("sb_keep", 64'(busy2[0]), 64'd1);
        tick();
        wr = 1; rd = 3; wv = 34;
        tick();
        wr = 0;
        #1 chk("sb_clr", 64'(busy2[0]), 64'd0);
        tick();
        wr = 1; rd = 10; wv = 10;
        tick();
        wr = 0; req = 1;
        b0 = beats; d0 = dones;
        tick();
        req = 0;
        for (int k = 0; k < 100 && dones == d0; k++) begin
            rdy = k[0];
            req = (k == 20);
            tick();
        end
        req = 0; rdy = 0;
        tick();
        tick();
        chk("dump_beats", 64'(beats - b0), 64'd32);
        chk("dump_dones", 64'(dones - d0), 64'd1);
        req = 1;
        tick();
        req = 0; rdy = 1;
        b0 = beats; d0 = dones;
        for (int k = 0; k < 50 && beats - b0 < 12; k++) tick();
        chk("rst_beat", 64'(beats - b0), 64'd12);
        reset = 1;
        tick();
        reset = 0; rdy = 0;
        #1 chk("rst_active", 64'(da2), 64'd0);
        for (int i = 0; i < 32; i++) begin
            for (int p = 0; p < 4; p++) rs4[p*5 +: 5] = 5'((i + 3*p) % 32);
            tick();
        end
        chk("rst_nodone", 64'(dones - d0), 64'd0);
        for (int k = 0; k < 600; k++) begin
            for (int p = 0; p < 4; p++)
                rs4[p*5 +: 5] = $urandom_range(0, 1) != 0 ?
                    5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wr    = $urandom_range(0, 1) != 0;
            rd    = 5'($urandom_range(0, 7));
            wv    = {$urandom, $urandom};
            iss   = $urandom_range(0, 9) < 3;
            ir    = 5'($urandom_range(0, 7));
            req   = $urandom_range(0, 19) == 0;
            rdy   = $urandom_range(0, 1) != 0;
            reset = $urandom_range(0, 199) == 0;
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised integer register file for the pipelined core.
- Configurable count of combinational read ports and one synchronous write port.
- x0 is hardwired to zero.
- Same-cycle write-to-read bypass.
- Per-register busy scoreboard for in-flight producers.
- Handshaked register-dump engine, replacing simulation-only print/finish debug.
- Sits between decode/issue (reads, issue marking) and writeback (writes, busy clear).

Parameters:
REGISTER_WIDTH, 64, data width of each register
REGISTERNO_WIDTH, 5, register index width; NUM_REGS = 2**REGISTERNO_WIDTH (derived, not overridable)
NUM_READ_PORTS, 2, number of independent read ports (>=1)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
in_rs_regno  input  NUM_READ_PORTS*REGISTERNO_WIDTH  read indices; port p at bits [p*REGISTERNO_WIDTH +: REGISTERNO_WIDTH]
out_rs_value  output  NUM_READ_PORTS*REGISTER_WIDTH  read data, packed as above
out_rs_busy  output  NUM_READ_PORTS  1 = register of port p has a pending producer
in_wr_enable  input  1  writeback valid
in_rd_regno  input  REGISTERNO_WIDTH  writeback destination
in_rd_value  input  REGISTER_WIDTH  writeback data
in_issue_valid  input  1  instruction with destination issued this cycle
in_issue_regno  input  REGISTERNO_WIDTH  issued destination; marks register busy
in_dump_req  input  1  start dump (sampled in IDLE only)
in_dump_ready  input  1  consumer accepts current dump beat
out_dump_valid  output  1  dump beat valid
out_dump_regno  output  REGISTERNO_WIDTH  index of current beat
out_dump_value  output  REGISTER_WIDTH  value of current beat
out_dump_done  output  1  one-cycle pulse after final beat accepted
out_dump_active  output  1  dump engine not IDLE

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high. reset has priority over every other input.
- Reset values: all registers 0; all busy bits 0; FSM in IDLE. out_dump_valid, out_dump_done, out_dump_active, out_dump_regno, out_dump_value all 0. Read outputs then reflect the zeroed array.
- Reads: combinational, zero latency, per port p.
  - If regno==0, value=0.
  - Else if in_wr_enable and in_rd_regno==regno, value=in_rd_value (bypass).
  - Else value=array[regno].
- Writes: on posedge, if in_wr_enable and in_rd_regno!=0, array[in_rd_regno] <= in_rd_value. Writes to x0 are dropped. Write is visible via the array from the next cycle.
- Scoreboard, next-state per register r!=0:
  - set if in_issue_valid and in_issue_regno==r;
  - else clear if in_wr_enable and in_rd_regno==r;
  - else hold.
  - Simultaneous issue and write to the same r leaves it busy (the new producer wins).
  - busy[0] is constant 0; issue to x0 is ignored.
- out_rs_busy[p] = busy[regno_p] AND NOT (in_wr_enable and in_rd_regno==regno_p and not (in_issue_valid and in_issue_regno==regno_p)). This makes the bypassed value report not-busy in the same cycle.
- Dump FSM states: IDLE, STREAM, DONE.
  - IDLE: if in_dump_req, go to STREAM with index=0.
  - STREAM: out_dump_valid=1, out_dump_regno=index, out_dump_value=array[index] (raw array, no bypass; index 0 reads 0).
    - Beat accepted when valid&ready.
    - On acceptance with index==NUM_REGS-1, go to DONE; else index+1.
    - Without ready, hold index; regno stays stable.
    - Value may change if the register is written while stalled.
  - DONE: out_dump_done=1 for exactly one cycle, then IDLE.
  - out_dump_active=1 in STREAM and DONE.
  - in_dump_req is ignored outside IDLE. A dump consumes no read ports, and writes/issues continue during a dump.
- Reset mid-dump: FSM returns to IDLE next cycle; no done pulse; array cleared.
- Index counter is REGISTERNO_WIDTH bits wide. Termination is by compare with NUM_REGS-1, not by overflow.

Test Plan:
- Reset then read x0..x31 on both ports -> all 0, all busy 0; write x5=0xDEAD, next cycle port0 rs=5 -> 0xDEAD.
- Write x0=0x1234 with port1 rs=0 same cycle and next cycle -> 0 both cycles; busy[0] stays 0 after issuing x0.
- Bypass: array x7=1; same cycle in_wr_enable, rd=7, value=99, port0 rs=7 -> out 99, busy 0; following cycle -> 99.
- Scoreboard: issue x3 -> next cycle busy=1; write x3 + issue x3 same cycle -> busy remains 1; later write x3 alone -> busy 0 following cycle.
- Dump with ready toggling every other cycle, x10=10 pre-loaded -> 32 beats, regno 0..31 in order, beat 10 value 10, done pulses once one cycle after beat 31; second dump_req during STREAM ignored.
- Assert reset at dump beat 12 -> active drops next cycle, no done pulse, all registers read 0; NUM_READ_PORTS=4 build gives identical per-port results.
